// File: rtl/alu_pkg.sv
// Shared definitions for the 10-bit ALU and its sequencer: opcodes, control sub-ops,
// instruction field positions, sequencer states and flag bit indices.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_SHIFT = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_ORR   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_XNOR  = 3'd6;
  localparam logic [2:0] OP_CTL   = 3'd7;

  localparam logic [2:0] CTL_JMP  = 3'd0;
  localparam logic [2:0] CTL_JZ   = 3'd1;
  localparam logic [2:0] CTL_JN   = 3'd2;
  localparam logic [2:0] CTL_JP   = 3'd3;
  localparam logic [2:0] CTL_JV   = 3'd4;
  localparam logic [2:0] CTL_HALT = 3'd5;
  localparam logic [2:0] CTL_NOP0 = 3'd6;
  localparam logic [2:0] CTL_NOP1 = 3'd7;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int IMM_BIT = 12;
  localparam int SUB_HI  = 12;
  localparam int SUB_LO  = 10;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 10;
  localparam int RB_HI   = 9;
  localparam int RB_LO   = 8;
  localparam int RA_HI   = 7;
  localparam int RA_LO   = 6;
  localparam int IMM8_HI = 7;
  localparam int IMM8_LO = 0;

  localparam int FLAG_NEG  = 3;
  localparam int FLAG_POS  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic logic jump_taken(input logic [2:0] sub, input logic [3:0] flags);
    case (sub)
      CTL_JMP: jump_taken = 1'b1;
      CTL_JZ:  jump_taken = flags[FLAG_ZERO];
      CTL_JN:  jump_taken = flags[FLAG_NEG];
      CTL_JP:  jump_taken = flags[FLAG_POS];
      CTL_JV:  jump_taken = flags[FLAG_OVF];
      default: jump_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational operand reads, one debug read,
// one synchronous write port, synchronous active-high clear.
module alu_regfile #(
  parameter int DATA_W = 10,
  parameter int NREGS  = 4,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic [ADDR_W-1:0] i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Storage: clear on reset, otherwise single write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (i_we) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = regs_q[i_raddr0];
  assign o_rdata1 = regs_q[i_raddr1];
  assign o_dbg    = regs_q[i_dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute control stage for the 10-bit ALU: three cycles per
// instruction, ALU writeback into a 4-entry regfile, flag-conditioned jumps and HALT.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 10,
  parameter int NREGS  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [PC_W-1:0]   o_pc,
  input  logic [15:0]       i_instr,
  output logic [DATA_W-1:0] o_alu_arg0,
  output logic [DATA_W-1:0] o_alu_arg1,
  output logic [DATA_W-1:0] o_alu_data,
  output logic [2:0]        o_alu_oper,
  output logic              o_alu_imm,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [3:0]        i_alu_flag,
  output logic [3:0]        o_flags,
  output logic              o_busy,
  output logic              o_halted,
  input  logic [1:0]        i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_reg
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      flags_q, flags_d;
  logic            busy_q, halted_q;

  logic [2:0] op_s;
  logic [2:0] sub_s;
  logic       imm_s;
  logic [1:0] rd_s, rb_s, ra_s;
  logic [7:0] imm8_s;
  logic       we_s;
  logic [2:0] alu_oper_s;
  logic       alu_imm_s;

  assign op_s   = ir_q[OP_HI:OP_LO];
  assign sub_s  = ir_q[SUB_HI:SUB_LO];
  assign imm_s  = ir_q[IMM_BIT];
  assign rd_s   = ir_q[RD_HI:RD_LO];
  assign rb_s   = ir_q[RB_HI:RB_LO];
  assign ra_s   = ir_q[RA_HI:RA_LO];
  assign imm8_s = ir_q[IMM8_HI:IMM8_LO];

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (we_s),
    .i_waddr  (rd_s),
    .i_wdata  (i_alu_result),
    .i_raddr0 (ra_s),
    .o_rdata0 (o_alu_arg0),
    .i_raddr1 (rb_s),
    .o_rdata1 (o_alu_arg1),
    .i_dbg_sel(i_dbg_sel),
    .o_dbg    (o_dbg_reg)
  );

  // Next-state, PC/IR/flag update and ALU control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flags_d    = flags_q;
    we_s       = 1'b0;
    alu_oper_s = OP_ADD;
    alu_imm_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (i_start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = i_instr;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PC_W'(1);
        if (op_s != OP_CTL) begin
          we_s       = 1'b1;
          flags_d    = i_alu_flag;
          alu_oper_s = op_s;
          alu_imm_s  = imm_s;
        end else begin
          case (sub_s)
            CTL_HALT: begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
            CTL_NOP0, CTL_NOP1: pc_d = pc_q + PC_W'(1);
            default: begin
              if (jump_taken(sub_s, flags_q)) begin
                pc_d = PC_W'(imm8_s);
              end else begin
                pc_d = pc_q + PC_W'(1);
              end
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers; reset wins over any in-flight instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= 16'h0000;
      flags_q  <= 4'b0000;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flags_q  <= flags_d;
      busy_q   <= (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign o_pc       = pc_q;
  assign o_alu_data = DATA_W'($signed(imm8_s));
  assign o_alu_oper = alu_oper_s;
  assign o_alu_imm  = alu_imm_s;
  assign o_flags    = flags_q;
  assign o_busy     = busy_q;
  assign o_halted   = halted_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control stage directly upstream of the 10-bit ALU: fetches 16-bit instructions from an external program ROM, decodes them, drives the ALU operand/opcode/immediate inputs, and writes the ALU result into a 4-entry register file and the flag nibble into a flag register.
- Also executes flag-conditioned jumps and HALT, making ALU + sequencer a minimal programmable datapath.

Parameters:
- PC_W, 8, program counter and ROM address width.
- DATA_W, 10, datapath width; must equal the ALU width.
- NREGS, 4, register-file depth; must be 4, set by the 2-bit register fields.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; starts execution from PC 0 when in IDLE or HALT.
- o_pc  out  PC_W  ROM address.
- i_instr  in  16  ROM data; valid exactly one cycle after o_pc changes.
- o_alu_arg0  out  DATA_W  regfile[ra] to ALU i_arg0.
- o_alu_arg1  out  DATA_W  regfile[rb] to ALU i_arg1.
- o_alu_data  out  DATA_W  sign-extended imm8 to ALU i_data.
- o_alu_oper  out  3  to ALU i_oper.
- o_alu_imm  out  1  to ALU i_imm.
- i_alu_result  in  DATA_W  ALU o_result, signed.
- i_alu_flag  in  4  ALU o_flag {NEG,POS,ZERO,OVF}.
- o_flags  out  4  registered flags.
- o_busy  out  1  high in FETCH, DECODE and EXEC.
- o_halted  out  1  high in HALT.
- i_dbg_sel  in  2  debug register select.
- o_dbg_reg  out  DATA_W  regfile[i_dbg_sel], combinational.

Behaviour:
- Instruction fields: [15:13] op; [12] imm; [11:10] rd; [9:8] rb; [7:6] ra; [7:0] imm8 or jump target.
- ALU op encoding, op 0..6: ADD=0, SUB=1, SHIFT=2, AND=3, ORR=4, XOR=5, XNOR=6.
- op=7 is the control group, sub-op in [12:10]: 0 JMP, 1 JZ (ZERO), 2 JN (NEG), 3 JP (POS), 4 JV (OVF), 5 HALT, 6/7 NOP.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset: state IDLE, PC 0, IR 0, all regs 0, o_flags 0, o_busy 0, o_halted 0.
- Reset has priority over everything, including mid-instruction: no writeback occurs in the reset cycle.
- IDLE or HALT, with i_start: PC <= 0, go to FETCH. Registers and flags are preserved across HALT->start.
- FETCH: o_pc = PC. Go to DECODE.
- DECODE: IR <= i_instr (ROM latency is 1). Go to EXEC.
- EXEC, ALU ops:
  - ALU outputs are driven combinationally from IR and the regfile.
  - End of cycle: regfile[rd] <= i_alu_result; o_flags <= i_alu_flag; PC <= PC+1; go to FETCH.
  - Imm form: o_alu_imm=1; o_alu_data = {imm8[7],imm8[7],imm8}; arg0 field ignored by the ALU.
- EXEC, jumps:
  - Taken: PC <= imm8 (zero-extended to PC_W). Not taken: PC <= PC+1.
  - Regfile and flags are unchanged. Unconditional JMP is always taken.
- EXEC, HALT: PC holds; go to HALT. NOP: PC+1.
- Outside EXEC: o_alu_oper=0, o_alu_imm=0; arg and data outputs are don't-care but stable from IR.
- rd==ra or rd==rb: operands are read before write within EXEC, i.e. the old value is used.
- PC wraps 255 -> 0 with no error.
- i_start while busy is ignored.
- Throughput: 3 cycles per instruction.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants (ADD..XNOR, shared with the ALU).
  - Control sub-op constants and the instruction field bit positions.
  - The state enum.
  - Flag bit indices: NEG=3, POS=2, ZERO=1, OVF=0.
- One sub-module, alu_regfile: 4x10 bits, two combinational read ports plus a debug read port, one synchronous write port, synchronous reset.

Test Plan:
- Imm add: program `ADD imm r1,5` then HALT (imm form, rb=r0=0), start -> r1=5, flags 0100, o_halted after 7 cycles from start.
- Overflow: r1=500, r2=100, `ADD r3=r1+r2` -> r3=-424 (600-1024), flags 1001. SUB 0-0 -> flags 0010.
- Branch: after ZERO set, `JZ 0x10` -> o_pc=0x10 on the next FETCH. With ZERO clear -> PC+1; regs and flags unchanged either way.
- Hazard: `ADD r1=r1+r1` with r1=3 -> r1=6 (old value read).
- Reset: assert i_rst during EXEC of a writing instruction -> no write; all regs 0, state IDLE, o_busy 0 next cycle.
- Wrap/restart: 255 NOPs reach PC 255, then PC 0. i_start in HALT restarts at PC 0 with regs preserved. i_start while busy has no effect.
